// File: rtl/four_bank_mem.sv
// Four-bank, word-interleaved main-memory model below the cache controller.
// One word request per cycle, bank = addr[2:1]; reads return a fixed 2 cycles after acceptance.
module four_bank_mem #(
  parameter int BANK_CYCLES     = 4,
  parameter int BANK_DEPTH_LOG2 = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic [3:0]  busy,
  output logic        stall,
  output logic        err
);

  localparam int         DEPTH = 1 << BANK_DEPTH_LOG2;
  localparam logic [2:0] LOAD  = 3'(BANK_CYCLES - 1);

  typedef logic [BANK_DEPTH_LOG2-1:0] idx_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] bank;
    idx_t       idx;
  } slot_t;

  logic [15:0] mem [4][DEPTH];
  logic [2:0]  count [4];
  slot_t       slot;

  logic        req;
  logic        illegal;
  logic        accept;
  logic [1:0]  req_bank;
  idx_t        req_idx;

  always_comb begin
    req      = rd | wr;
    illegal  = (rd & wr) | (req & addr[0]);
    req_bank = addr[2:1];
    req_idx  = addr[3 +: BANK_DEPTH_LOG2];
    err      = illegal;
    stall    = req & ~illegal & busy[req_bank];
    // Requests seen while rst is high are dropped, so nothing is written during reset.
    accept   = req & ~illegal & ~busy[req_bank] & ~rst;
  end

  always_comb begin
    for (int b = 0; b < 4; b++) busy[b] = (count[b] != 3'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (rst)                                  count[b] <= 3'd0;
      else if (accept && req_bank == 2'(b))     count[b] <= LOAD;
      else if (count[b] != 3'd0)                count[b] <= count[b] - 3'd1;
    end
  end

  // Address slot plus the registered data word form the two read stages;
  // the slot's bank stays busy while it is read, so no write can race it.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      data_out <= 16'h0000;
    end else begin
      slot     <= '{valid: accept & rd, bank: req_bank, idx: req_idx};
      data_out <= slot.valid ? mem[slot.bank][slot.idx] : 16'h0000;
    end
  end

  // NOTE: the array is deliberately left out of reset; clearing thousands of
  // words would prevent a RAM mapping and the contents are allowed to be X.
  always_ff @(posedge clk) begin
    if (accept && wr) mem[req_bank][req_idx] <= data_in;
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// Self-checking bench for four_bank_mem: directed vector table plus hand-written reset sequences.
module tb_four_bank_mem;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic [3:0]  busy;
  logic        stall;
  logic        err;

  int checks = 0;
  int errors = 0;

  four_bank_mem #(.BANK_CYCLES(4), .BANK_DEPTH_LOG2(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .busy     (busy),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  busy;
    logic        stall;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] dout,
                              input logic [3:0] b, input logic s, input logic e);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d;
    v.dout = dout; v.busy = b; v.stall = s; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Write then read of 0x1230 (bank 0)
    tbl.push_back(mk(0, 1, 16'h1230, 16'hBEEF, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(1, 0, 16'h1230, 16'h0000, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'hBEEF, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    // Prewrite the line 0x0008..0x000E across all four banks
    tbl.push_back(mk(0, 1, 16'h0008, 16'h1111, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h000A, 16'h2222, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 1, 16'h000C, 16'h3333, 16'h0000, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 1, 16'h000E, 16'h4444, 16'h0000, 4'b0111, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1110, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1100, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 0, 0));
    // Back-to-back line fill
    tbl.push_back(mk(1, 0, 16'h0008, 16'h0000, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 16'h000A, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(1, 0, 16'h000C, 16'h0000, 16'h1111, 4'b0011, 0, 0));
    tbl.push_back(mk(1, 0, 16'h000E, 16'h0000, 16'h2222, 4'b0111, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h3333, 4'b1110, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h4444, 4'b1100, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 0, 0));
    // Seed word 0x0000 for the conflict and error tests
    tbl.push_back(mk(0, 1, 16'h0000, 16'hA5A5, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    // Same-bank conflict: retry accepted on the expiry cycle
    tbl.push_back(mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0008, 16'h0000, 16'h0000, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0008, 16'h0000, 16'hA5A5, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0008, 16'h0000, 16'h0000, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0008, 16'h0000, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h1111, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    // Illegal requests leave banks and memory untouched
    tbl.push_back(mk(1, 1, 16'h0000, 16'hDEAD, 16'h0000, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0001, 16'hDEAD, 16'h0000, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0000, 16'hDEAD, 16'h0000, 4'b0001, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0003, 16'hDEAD, 16'hA5A5, 4'b0001, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0, 0));

    // Reset held two cycles with a read request present
    rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
    #2;
    check("reset0 err", 16'(err), 16'h0);
    next_cycle();
    check("reset1 busy", 16'(busy), 16'h0);
    check("reset1 data_out", data_out, 16'h0000);
    check("reset1 err", 16'(err), 16'h0);
    check("reset1 stall", 16'(stall), 16'h0);
    next_cycle();
    rst = 1'b0; rd = 1'b0;
    #1;
    check("reset2 busy", 16'(busy), 16'h0);
    check("reset2 data_out", data_out, 16'h0000);
    next_cycle();
    check("reset3 busy", 16'(busy), 16'h0);
    check("reset3 data_out", data_out, 16'h0000);
    next_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; data_in = tbl[i].din;
      #1;
      check($sformatf("row%0d data_out", i), data_out, tbl[i].dout);
      check($sformatf("row%0d busy", i), 16'(busy), 16'(tbl[i].busy));
      check($sformatf("row%0d stall", i), 16'(stall), 16'(tbl[i].stall));
      check($sformatf("row%0d err", i), 16'(err), 16'(tbl[i].err));
      next_cycle();
    end

    // Reset mid-read: in-flight read dropped, request during rst ignored
    rd = 1'b1; wr = 1'b0; addr = 16'h0002; data_in = 16'h0000;
    #1;
    check("midrst accept stall", 16'(stall), 16'h0);
    next_cycle();
    rst = 1'b1; rd = 1'b0; wr = 1'b1; addr = 16'h0000; data_in = 16'hFFFF;
    #1;
    check("midrst busy before reset", 16'(busy), 16'h2);
    next_cycle();
    rst = 1'b0; wr = 1'b0;
    #1;
    check("midrst data_out", data_out, 16'h0000);
    check("midrst busy", 16'(busy), 16'h0);
    next_cycle();
    rd = 1'b1; addr = 16'h0000;
    #1;
    check("midrst no late return", data_out, 16'h0000);
    check("midrst read accepted", 16'(stall), 16'h0);
    next_cycle();
    rd = 1'b0;
    #1;
    check("postrst busy", 16'(busy), 16'h1);
    check("postrst data_out early", data_out, 16'h0000);
    next_cycle();
    check("postrst kept write", data_out, 16'hA5A5);
    next_cycle();
    check("postrst data_out idle", data_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
